// File: rtl/jump_pc_unit.sv
// Program counter and control-transfer unit: decodes J/JAL/JR/BEQ/BNE and owns the PC.
// Keeps a circular return-address stack that cross-checks JR $31 targets.
module jump_pc_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                RAS_DEPTH  = 4,
    parameter int                DELAY_SLOT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       inst_code,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] link_addr,
    output logic              Write_Reg,
    output logic [1:0]        w_r_s,
    output logic [1:0]        wr_data_s,
    output logic              Mem_Write,
    output logic              taken,
    output logic              ras_ovf,
    output logic              ras_unf,
    output logic              ras_miss
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [ADDR_W-1:0] SEQ_OFF  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LINK_OFF = (DELAY_SLOT != 0) ? ADDR_W'(8) : ADDR_W'(4);
    localparam logic [CNT_W-1:0]  RAS_FULL = CNT_W'(RAS_DEPTH);

    function automatic logic signed [ADDR_W-1:0] br_offset(input logic [15:0] imm);
        return {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    endfunction

    logic [5:0]        op;
    logic [5:0]        fn;
    logic [4:0]        rs_idx;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic signed [ADDR_W-1:0] br_off;
    logic              ras_push;
    logic              ras_pop;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ras_rd_ptr;
    logic [CNT_W-1:0]  ras_cnt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    logic              pend_v;
    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_v_next;
    logic [ADDR_W-1:0] pc_next;

    assign op      = inst_code[31:26];
    assign fn      = inst_code[5:0];
    assign rs_idx  = inst_code[25:21];
    assign pc4     = pc_out + SEQ_OFF;
    assign jmp_tgt = {pc4[ADDR_W-1:28], inst_code[25:0], 2'b00};
    assign br_off  = br_offset(inst_code[15:0]);
    assign br_tgt  = pc4 + $unsigned(br_off);
    assign jr_tgt  = rs_data[ADDR_W-1:0];

    assign link_addr = pc_out + LINK_OFF;
    assign Mem_Write = 1'b0;

    // Decode: everything here is forced inactive while reset is held
    always_comb begin
        taken     = 1'b0;
        Write_Reg = 1'b0;
        w_r_s     = 2'b00;
        wr_data_s = 2'b00;
        tgt       = pc4;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        if (!rst) begin
            case (op)
                OP_J: begin
                    taken = 1'b1;
                    tgt   = jmp_tgt;
                end
                OP_JAL: begin
                    taken     = 1'b1;
                    tgt       = jmp_tgt;
                    Write_Reg = 1'b1;
                    w_r_s     = 2'b10;
                    wr_data_s = 2'b10;
                    ras_push  = 1'b1;
                end
                OP_RTYPE: begin
                    if (fn == FN_JR) begin
                        taken   = 1'b1;
                        tgt     = jr_tgt;
                        ras_pop = (rs_idx == 5'd31);
                    end
                end
                OP_BEQ: begin
                    taken = (rs_data == rt_data);
                    tgt   = br_tgt;
                end
                OP_BNE: begin
                    taken = (rs_data != rt_data);
                    tgt   = br_tgt;
                end
                default: begin
                    taken = 1'b0;
                end
            endcase
        end
    end

    // Without a delay slot the redirect is immediate; with one, the target waits a cycle
    always_comb begin
        if (DELAY_SLOT != 0) begin
            pc_next     = pend_v ? pend_tgt : pc4;
            pend_v_next = taken;
        end else begin
            pc_next     = taken ? tgt : pc4;
            pend_v_next = 1'b0;
        end
    end

    assign ras_rd_ptr = ras_ptr - 1'b1;
    assign ras_top    = ras_mem[ras_rd_ptr];
    assign ras_full   = (ras_cnt == RAS_FULL);
    assign ras_empty  = (ras_cnt == '0);

    // Control state: PC, stack pointer/count, pending flag and check pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= RESET_PC;
            ras_ptr  <= '0;
            ras_cnt  <= '0;
            pend_v   <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            ras_miss <= 1'b0;
        end else if (stall) begin
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            ras_miss <= 1'b0;
        end else begin
            pc_out   <= pc_next;
            pend_v   <= pend_v_next;
            ras_ovf  <= ras_push && ras_full;
            ras_unf  <= ras_pop && ras_empty;
            ras_miss <= ras_pop && !ras_empty && (ras_top != jr_tgt);
            if (ras_push) begin
                // A full stack wraps onto its oldest entry, so the count saturates
                ras_ptr <= ras_ptr + 1'b1;
                if (!ras_full) begin
                    ras_cnt <= ras_cnt + 1'b1;
                end
            end else if (ras_pop && !ras_empty) begin
                ras_ptr <= ras_rd_ptr;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end

    // Data storage: stack entries and pending target carry no reset
    always_ff @(posedge clk) begin
        if (!rst && !stall) begin
            if (ras_push) begin
                ras_mem[ras_ptr] <= link_addr;
            end
            if (taken) begin
                pend_tgt <= tgt;
            end
        end
    end

endmodule
